egg_field_manager: RTL

//  Parametrised collectible manager: NUM_EGGS independent eggs, each placed on one of 20 fixed

---
 rtl/egg_field_manager.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/egg_field_manager.sv
// Collectible egg manager: per-egg ACTIVE/WAIT FSMs on a fixed slot table, LFSR-driven
// respawn placement, single-winner collection arbitration and a ripple-carry BCD score.
module egg_field_manager #(
    parameter int          NUM_EGGS      = 4,
    parameter int          SCORE_DIGITS  = 4,
    parameter int          RESPAWN_TICKS = 60,
    parameter int          CHAR_SIZE     = 32,
    parameter int          EGG_SIZE      = 32,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic [10:0]               yoshi_x,
    input  logic [9:0]                yoshi_y,
    output logic [11*NUM_EGGS-1:0]    egg_x,
    output logic [10*NUM_EGGS-1:0]    egg_y,
    output logic [NUM_EGGS-1:0]       egg_valid,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic                      collect,
    output logic                      score_wrap
);

    localparam int          CNT_W       = $clog2(RESPAWN_TICKS + 1);
    localparam logic [CNT_W-1:0] RESPAWN_CNT = CNT_W'(RESPAWN_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [11:0] EGG_X12     = 12'(EGG_SIZE);
    localparam logic [11:0] CHAR_X12    = 12'(CHAR_SIZE);
    localparam logic [10:0] EGG_Y11     = 11'(EGG_SIZE);
    localparam logic [10:0] CHAR_Y11    = 11'(CHAR_SIZE);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_WAIT   = 1'b1
    } egg_state_t;

    function automatic logic [9:0] slot_y(input logic [1:0] lvl);
        logic [9:0] r;
        case (lvl)
            2'd0:    r = 10'd732;
            2'd1:    r = 10'd573;
            2'd2:    r = 10'd393;
            default: r = 10'd213;
        endcase
        return r;
    endfunction

    function automatic logic [10:0] slot_x(input logic [1:0] lvl, input logic [2:0] col);
        logic [10:0] r;
        case (lvl)
            2'd0: begin
                case (col)
                    3'd0:    r = 11'd140;
                    3'd1:    r = 11'd350;
                    3'd2:    r = 11'd560;
                    3'd3:    r = 11'd770;
                    default: r = 11'd980;
                endcase
            end
            2'd2: begin
                case (col)
                    3'd0:    r = 11'd80;
                    3'd1:    r = 11'd420;
                    3'd2:    r = 11'd785;
                    3'd3:    r = 11'd971;
                    default: r = 11'd1157;
                endcase
            end
            default: begin
                case (col)
                    3'd0:    r = 11'd280;
                    3'd1:    r = 11'd450;
                    3'd2:    r = 11'd620;
                    3'd3:    r = 11'd790;
                    default: r = 11'd960;
                endcase
            end
        endcase
        return r;
    endfunction

    // Column draws 5..7 fold back onto 0..2 so every draw maps to a real slot.
    function automatic logic [2:0] fold_col(input logic [2:0] c);
        return (c >= 3'd5) ? (c - 3'd5) : c;
    endfunction

    egg_state_t        state_q [NUM_EGGS];
    egg_state_t        state_d [NUM_EGGS];
    logic [CNT_W-1:0]  cnt_q   [NUM_EGGS];
    logic [CNT_W-1:0]  cnt_d   [NUM_EGGS];
    logic [10:0]       ex_q    [NUM_EGGS];
    logic [10:0]       ex_d    [NUM_EGGS];
    logic [9:0]        ey_q    [NUM_EGGS];
    logic [9:0]        ey_d    [NUM_EGGS];
    logic [3:0]        score_q [SCORE_DIGITS];
    logic [3:0]        score_d [SCORE_DIGITS];
    logic [15:0]       lfsr_q, lfsr_d;
    logic              collect_q, wrap_q, wrap_d;

    logic [NUM_EGGS-1:0] overlap, grant, place_ok;
    logic                any_grant, blocked, placing_seen, carry;
    logic [10:0]         cand_x;
    logic [9:0]          cand_y;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cand_x = slot_x(lfsr_q[1:0], fold_col(lfsr_q[4:2]));
    assign cand_y = slot_y(lfsr_q[1:0]);

    always_comb begin : arbitration
        overlap      = '0;
        grant        = '0;
        place_ok     = '0;
        any_grant    = 1'b0;
        blocked      = 1'b0;
        placing_seen = 1'b0;
        for (int i = 0; i < NUM_EGGS; i++) begin
            overlap[i] = (state_q[i] == ST_ACTIVE)
                      && ({1'b0, yoshi_x} <= {1'b0, ex_q[i]} + EGG_X12)
                      && ({1'b0, yoshi_x} + CHAR_X12 >= {1'b0, ex_q[i]})
                      && ({1'b0, yoshi_y} <= {1'b0, ey_q[i]} + EGG_Y11)
                      && ({1'b0, yoshi_y} + CHAR_Y11 >= {1'b0, ey_q[i]});
            if (state_q[i] == ST_ACTIVE && ex_q[i] == cand_x && ey_q[i] == cand_y)
                blocked = 1'b1;
        end
        // All placers share one candidate, so only the lowest-index one can ever land.
        for (int i = 0; i < NUM_EGGS; i++) begin
            if (overlap[i] && !any_grant) begin
                grant[i]  = 1'b1;
                any_grant = 1'b1;
            end
            if (state_q[i] == ST_WAIT && cnt_q[i] == '0) begin
                if (!blocked && !placing_seen)
                    place_ok[i] = 1'b1;
                placing_seen = 1'b1;
            end
        end
    end

    always_comb begin : egg_next
        for (int i = 0; i < NUM_EGGS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            ex_d[i]    = ex_q[i];
            ey_d[i]    = ey_q[i];
            case (state_q[i])
                ST_ACTIVE: begin
                    if (grant[i]) begin
                        state_d[i] = ST_WAIT;
                        cnt_d[i]   = RESPAWN_CNT;
                    end
                end
                default: begin
                    if (cnt_q[i] != '0) begin
                        if (tick)
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end else if (place_ok[i]) begin
                        state_d[i] = ST_ACTIVE;
                        ex_d[i]    = cand_x;
                        ey_d[i]    = cand_y;
                    end
                end
            endcase
        end
    end

    always_comb begin : score_next
        carry = any_grant;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            score_d[d] = score_q[d];
            if (carry) begin
                if (score_q[d] == 4'd9) begin
                    score_d[d] = 4'd0;
                end else begin
                    score_d[d] = score_q[d] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
        wrap_d = carry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q    <= SEED;
            collect_q <= 1'b0;
            wrap_q    <= 1'b0;
            for (int i = 0; i < NUM_EGGS; i++) begin
                state_q[i] <= ST_ACTIVE;
                cnt_q[i]   <= '0;
                ex_q[i]    <= slot_x(2'd1, 3'(i));
                ey_q[i]    <= slot_y(2'd1);
            end
            for (int d = 0; d < SCORE_DIGITS; d++)
                score_q[d] <= 4'd0;
        end else begin
            lfsr_q    <= lfsr_d;
            collect_q <= any_grant;
            wrap_q    <= wrap_d;
            for (int i = 0; i < NUM_EGGS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                ex_q[i]    <= ex_d[i];
                ey_q[i]    <= ey_d[i];
            end
            for (int d = 0; d < SCORE_DIGITS; d++)
                score_q[d] <= score_d[d];
        end
    end

    always_comb begin : pack_outputs
        egg_x     = '0;
        egg_y     = '0;
        egg_valid = '0;
        score_bcd = '0;
        for (int i = 0; i < NUM_EGGS; i++) begin
            egg_x[11*i +: 11] = ex_q[i];
            egg_y[10*i +: 10] = ey_q[i];
            egg_valid[i]      = (state_q[i] == ST_ACTIVE);
        end
        for (int d = 0; d < SCORE_DIGITS; d++)
            score_bcd[4*d +: 4] = score_q[d];
    end

    assign collect    = collect_q;
    assign score_wrap = wrap_q;

endmodule
